// File: rtl/sequential_divider.sv
// sequential_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module sequential_divider #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic             accept;
   logic [WIDTH:0]   sh;
   logic [WIDTH+1:0] trial;

   // next-state: operand capture on accepted start, one restoring step per RUN cycle
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      accept  = start && (state_q != RUN);
      sh      = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      trial   = {1'b0, sh} - {2'b00, dvs_q};
      if (accept) begin
         dvs_d = divisor;
         cnt_d = '0;
         if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = {1'b0, dividend};
            dbz_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end else begin
            state_d = RUN;
            quo_d   = dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
         end
      end else if (state_q == RUN) begin
         quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
         rem_d = trial[WIDTH+1] ? sh : trial[WIDTH:0];
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   // state and registered outputs, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q[WIDTH-1:0];
   assign div_by_zero = dbz_q;
endmodule

// File: doc/sequential_divider.md
# sequential_divider

Multi-cycle unsigned restoring divider for the ALU, the inverse of the shift-add multiplier. It takes a WIDTH-bit dividend and divisor and produces a WIDTH-bit quotient and remainder. It resolves one quotient bit per clock using a single WIDTH+1-bit subtractor, and it sits beside the multiplier behind a start/done handshake.

## Interface
- WIDTH, 64, operand, quotient and remainder width; must be ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when the block is not busy
- dividend  input  WIDTH  numerator; captured on an accepted start
- divisor  input  WIDTH  denominator; captured on an accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; results are valid from this cycle on
- quotient  output  WIDTH  floor(dividend / divisor)
- remainder  output  WIDTH  dividend mod divisor
- div_by_zero  output  1  set with done when the captured divisor was 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with start=1 (accepted start):
  - captures dividend into the quotient/shift register, divisor into an internal register, and clears remainder to 0 and the counter to 0.
  - With divisor≠0, moves to RUN and sets busy=1.
  - With divisor=0, moves directly to DONE and sets quotient=all ones, remainder=dividend, div_by_zero=1.
- IDLE, start=0: holds. Outputs keep their last values.
- RUN, per cycle:
  - shift {remainder, quotient} left by 1.
  - trial = {1'b0, shifted remainder} − {1'b0, divisor}, WIDTH+1 bits.
  - If trial is non-negative, remainder=trial[WIDTH-1:0] and quotient LSB=1. Otherwise remainder keeps the shifted value and quotient LSB=0.
  - Counter increments. After the WIDTH-th iteration, moves to DONE.
- Register widths: remainder uses WIDTH+1 bits internally, and the shift carry must not be lost. Outputs are the low WIDTH bits.
- DONE: done=1 and busy=0 for exactly one cycle, then moves to IDLE unless a new start is accepted that same cycle.
- start while busy (RUN) is ignored. Operands are not re-sampled and the operation is not restarted.
- div_by_zero is cleared on every accepted start and then reflects the new operation.
- Operands may change after acceptance without affecting the result.

## Timing
- Reset values: busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, state=IDLE, counter=0.
- Latency, divisor≠0: start accepted at edge 0; iterations occur at edges 1..WIDTH; done is high in the cycle following edge WIDTH. That is WIDTH+1 cycles from start to done, 65 for the default.
- Latency, divisor=0: done is high in the cycle following edge 0, i.e. 1 cycle.
- busy is high from the cycle after edge 0 through the cycle after edge WIDTH−1, and low when done is high.
- Back-to-back: start=1 during the done cycle is accepted. The next result's done then follows WIDTH+1 cycles later with no idle gap.
- quotient, remainder and div_by_zero are stable from the done cycle until the next accepted start.
- Reset mid-operation (rst=1 at any edge): all outputs return to reset values at that edge, no done is produced, and start in the same cycle as rst is ignored.

## Test plan
- 100 / 7, WIDTH=64: start one cycle → done exactly 65 cycles later, quotient=14, remainder=2, div_by_zero=0, busy low in the done cycle.
- 0xFFFF_FFFF_FFFF_FFFF / 1 → quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0. Then 5 / 9 → quotient=0, remainder=5. Then 0 / 3 → quotient=0, remainder=0.
- Divisor 0, dividend 0x1234 → done 1 cycle after start, quotient=all ones, remainder=0x1234, div_by_zero=1. The next valid divide clears div_by_zero.
- Start 100/7, pulse start with 50/5 at cycle 20 and change the operand inputs → the second start is ignored, done stays at cycle 65 and the result is 14 r 2. Start 50/5 during the done cycle → done 65 cycles later with 10 r 0.
- Assert rst at cycle 30 of a divide → busy=0, quotient=0, remainder=0, no done pulse within 100 cycles. A fresh start 9/4 → 2 r 1.
- Random unsigned operands (≥1000, including divisor > dividend and divisor=2^63) → quotient*divisor+remainder == dividend and remainder < divisor for every done.
